// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the fetch-PC sequencing controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam int     PC_STEP     = 4;
  localparam state_e RST_STATE   = RUN;
  localparam logic   RST_HALTED  = 1'b0;
  localparam logic   RST_FAULT   = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC owner: picks the next PC each cycle and drives IF/ID and ID/EX
// enable/flush controls, with halt drain and misaligned-redirect trapping.
//
//   state  | meaning
//   RUN    | normal fetch; halt > misaligned > redirect > stall > sequential
//   DRAIN  | halt accepted, waiting for MEM/WB to retire
//   HALTED | core stopped until reset
//   FAULT  | misaligned redirect trapped, stopped until reset
module pc_redirect_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int PC_W      = 9,
  parameter int RESET_PC  = 0,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_pc_sel,
  input  logic [31:0]      ex_br_pc,
  input  logic             ex_halt,
  input  logic             load_use_stall,
  output logic [PC_W-1:0]  pc,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int               DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYC - 1);
  localparam logic [DW-1:0]    DRAIN_DEC  = DW'(1);
  localparam logic [PC_W-1:0]  PC_INC     = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0]  PC_RST     = PC_W'(RESET_PC);

  state_e            r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [DW-1:0]     r_drain_cnt, w_drain_nxt;
  logic              r_fault, w_fault_nxt;
  logic              r_halted, w_halted_nxt;
  logic              w_halt_req, w_redir_req, w_misaligned;
  logic              w_redirect_inc, w_stall_inc;
  logic              w_unused_br_hi;

  assign w_halt_req   = ex_valid && ex_halt;
  assign w_redir_req  = ex_valid && ex_pc_sel;
  assign w_misaligned = (ex_br_pc[1:0] != 2'b00);

  // Target bits above the PC width are dropped without any range check.
  assign w_unused_br_hi = ^ex_br_pc[31:PC_W];

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drain_nxt    = r_drain_cnt;
    w_fault_nxt    = r_fault;
    w_halted_nxt   = r_halted;
    pc_en          = 1'b0;
    if_id_en       = 1'b0;
    if_id_flush    = 1'b1;
    id_ex_flush    = 1'b1;
    w_redirect_inc = 1'b0;
    w_stall_inc    = 1'b0;

    case (r_state)
      RUN: begin
        if (w_halt_req) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = DRAIN_LOAD;
        end else if (w_redir_req && w_misaligned) begin
          w_state_nxt = FAULT;
          w_fault_nxt = 1'b1;
        end else if (w_redir_req) begin
          w_pc_nxt       = ex_br_pc[PC_W-1:0];
          pc_en          = 1'b1;
          if_id_en       = 1'b1;
          w_redirect_inc = 1'b1;
        end else if (load_use_stall) begin
          // Hold fetch/decode and inject a bubble into EX.
          if_id_flush = 1'b0;
          w_stall_inc = 1'b1;
        end else begin
          w_pc_nxt    = r_pc + PC_INC;
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          if_id_flush = 1'b0;
          id_ex_flush = 1'b0;
        end
      end
      DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_nxt  = HALTED;
          w_halted_nxt = 1'b1;
        end else begin
          w_drain_nxt = r_drain_cnt - DRAIN_DEC;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RST_STATE;
      r_pc        <= PC_RST;
      r_drain_cnt <= '0;
      r_fault     <= RST_FAULT;
      r_halted    <= RST_HALTED;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_drain_cnt <= w_drain_nxt;
      r_fault     <= w_fault_nxt;
      r_halted    <= w_halted_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (w_redirect_inc),
    .clear (1'b0),
    .count (redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc   (w_stall_inc),
    .clear (1'b0),
    .count (stall_cnt)
  );

  assign pc     = r_pc;
  assign halted = r_halted;
  assign fault  = r_fault;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl with a per-cycle expectation queue.
module tb_pc_redirect_ctrl;

  localparam int PC_W  = 9;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ex_valid = 1'b0;
  logic             ex_pc_sel = 1'b0;
  logic [31:0]      ex_br_pc = 32'h0;
  logic             ex_halt = 1'b0;
  logic             load_use_stall = 1'b0;
  logic [PC_W-1:0]  pc;
  logic             pc_en, if_id_en, if_id_flush, id_ex_flush, halted, fault;
  logic [CNT_W-1:0] redirect_cnt, stall_cnt;

  pc_redirect_ctrl #(
    .PC_W(PC_W), .RESET_PC(0), .DRAIN_CYC(2), .CNT_W(CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_pc_sel      (ex_pc_sel),
    .ex_br_pc       (ex_br_pc),
    .ex_halt        (ex_halt),
    .load_use_stall (load_use_stall),
    .pc             (pc),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .halted         (halted),
    .fault          (fault),
    .redirect_cnt   (redirect_cnt),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0]  pc;
    logic        pc_en, if_id_en, if_id_flush, id_ex_flush, halted, fault;
    logic [15:0] rc, sc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: 0 run, 1 drain, 2 halted, 3 fault
  int          m_state;
  int          m_left;
  logic [8:0]  m_pc;
  logic [15:0] m_rc, m_sc;
  logic        m_fault, m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_left = 0; m_pc = 9'd0;
    m_rc = 16'd0; m_sc = 16'd0; m_fault = 1'b0; m_halted = 1'b0;
  endtask

  // Called at a falling edge; drives one cycle and returns at the next falling edge.
  task automatic step(input logic v, input logic sel, input logic [31:0] br,
                      input logic h, input logic st, input bit do_chk);
    exp_t e;
    exp_t x;
    ex_valid = v; ex_pc_sel = sel; ex_br_pc = br; ex_halt = h; load_use_stall = st;
    e.pc = m_pc; e.halted = m_halted; e.fault = m_fault; e.rc = m_rc; e.sc = m_sc;
    e.pc_en = 1'b0; e.if_id_en = 1'b0; e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
    if (m_state == 0) begin
      if (v && h) begin
        m_state = 1; m_left = 2;
      end else if (v && sel && (br[1:0] != 2'b00)) begin
        m_state = 3; m_fault = 1'b1;
      end else if (v && sel) begin
        e.pc_en = 1'b1; e.if_id_en = 1'b1;
        m_pc = br[8:0];
        if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
      end else if (st) begin
        e.if_id_flush = 1'b0;
        if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      end else begin
        e.pc_en = 1'b1; e.if_id_en = 1'b1; e.if_id_flush = 1'b0; e.id_ex_flush = 1'b0;
        m_pc = m_pc + 9'd4;
      end
    end else if (m_state == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_state = 2; m_halted = 1'b1;
      end
    end
    if (do_chk) sb.push_back(e);
    #2;
    if (do_chk) begin
      x = sb.pop_front();
      chk("pc", pc, x.pc);
      chk("pc_en", pc_en, x.pc_en);
      chk("if_id_en", if_id_en, x.if_id_en);
      chk("if_id_flush", if_id_flush, x.if_id_flush);
      chk("id_ex_flush", id_ex_flush, x.id_ex_flush);
      chk("halted", halted, x.halted);
      chk("fault", fault, x.fault);
      chk("redirect_cnt", redirect_cnt, x.rc);
      chk("stall_cnt", stall_cnt, x.sc);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse starting away from any clock edge.
  task automatic do_reset();
    ex_valid = 1'b0; ex_pc_sel = 1'b0; ex_halt = 1'b0; load_use_stall = 1'b0;
    reset = 1'b1;
    model_reset();
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fault", fault, 32'h0);
    chk("rst_halted", halted, 32'h0);
    chk("rst_rcnt", redirect_cnt, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_pc", pc, 32'h0);
    chk("init_scnt", stall_cnt, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t1_pc", pc, 32'h10);
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    chk("t2_pc", pc, 32'h40);
    chk("t2_rcnt", redirect_cnt, 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_seq", pc, 32'h44);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
    chk("invalid_ignored", pc, 32'h48);

    step(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    chk("t3_hold", pc, 32'h20);
    chk("t3_scnt", stall_cnt, 32'h1);
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 1'b1);
    chk("t3_redir_wins", pc, 32'h80);
    chk("t3_scnt_same", stall_cnt, 32'h1);

    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("drain_rst_run", pc, 32'h4);

    step(1'b1, 1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1);
    chk("t4_pc_hold", pc, 32'h30);
    chk("t4_halted_e0", halted, 32'h0);
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    chk("t4_halted_e1", halted, 32'h0);
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1);
    chk("t4_halted_e2", halted, 32'h1);
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t4_pc_frozen", pc, 32'h30);

    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 1'b1);
    chk("t5_fault", fault, 32'h1);
    chk("t5_pc", pc, 32'h4);
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("t5_sticky", fault, 32'h1);
    chk("t5_halted_low", halted, 32'h0);
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t5_run", pc, 32'h4);

    step(1'b1, 1'b1, 32'h1FC, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("t6_wrap", pc, 32'h0);
    step(1'b1, 1'b1, 32'hFFFF_FE08, 1'b0, 1'b0, 1'b1);
    chk("t6_trunc", pc, 32'h8);
    for (int i = 0; i < 65535; i++) step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    chk("t6_rcnt_sat", redirect_cnt, 32'hFFFF);
    step(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 1'b1);
    chk("t6_rcnt_hold", redirect_cnt, 32'hFFFF);
    chk("t6_pc", pc, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
